// File: rtl/ext_pkg.sv
// Shared definitions for the immediate/load extension unit:
// mode encodings and result FIFO depth.
package ext_pkg;

    typedef enum logic [2:0] {
        MODE_ZIMM = 3'd0,
        MODE_SIMM = 3'd1,
        MODE_LUI  = 3'd2,
        MODE_LBU  = 3'd3,
        MODE_LB   = 3'd4,
        MODE_LHU  = 3'd5,
        MODE_LH   = 3'd6,
        MODE_WORD = 3'd7
    } ext_mode_e;

    localparam int EXT_DEPTH = 2;

endpackage

// File: rtl/ext_core.sv
// Combinational extract/extend stage: selects the immediate, byte or halfword
// for the requested mode and flags misaligned halfword/word accesses.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  ext_mode_e          mode,
    input  logic [DATA_W-1:0]  data,
    input  logic [OFF_W-1:0]   off,
    output logic [DATA_W-1:0]  result,
    output logic               err
);

    logic [DATA_W-1:0] shifted;

    // Little-endian lanes: bringing the addressed byte down to bit 0.
    assign shifted = data >> {off, 3'b000};

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (mode)
            MODE_ZIMM: begin
                for (int i = 0; i < IMM_W; i++) result[i] = data[i];
            end
            MODE_SIMM: begin
                for (int i = 0; i < DATA_W; i++)
                    result[i] = (i < IMM_W) ? data[i] : data[IMM_W-1];
            end
            MODE_LUI: begin
                for (int i = 0; i < IMM_W; i++) result[DATA_W-IMM_W+i] = data[i];
            end
            MODE_LBU: begin
                result[7:0] = shifted[7:0];
            end
            MODE_LB: begin
                for (int i = 0; i < DATA_W; i++)
                    result[i] = (i < 8) ? shifted[i] : shifted[7];
            end
            MODE_LHU: begin
                if (off[0]) err = 1'b1;
                else        result[15:0] = shifted[15:0];
            end
            MODE_LH: begin
                if (off[0]) begin
                    err = 1'b1;
                end else begin
                    for (int i = 0; i < DATA_W; i++)
                        result[i] = (i < 16) ? shifted[i] : shifted[15];
                end
            end
            MODE_WORD: begin
                if (off != '0) err = 1'b1;
                else           result = data;
            end
            default: begin
                result = '0;
                err    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ext_unit.sv
// Extension unit top: computes the extended result on acceptance and queues it
// in a small FIFO with valid/ready handshakes on both sides.
module ext_unit
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam logic [1:0] FULL_COUNT = 2'(EXT_DEPTH);

    logic [DATA_W-1:0] core_result;
    logic              core_err;

    logic [DATA_W:0]   mem_q [EXT_DEPTH];
    logic [DATA_W:0]   mem_d [EXT_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push, pop;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFF_W  (OFF_W)
    ) u_core (
        .mode   (ext_mode_e'(in_mode)),
        .data   (in_data),
        .off    (in_off),
        .result (core_result),
        .err    (core_err)
    );

    // Handshakes depend only on registered count, so out_ready never reaches in_ready.
    assign in_ready  = reset && (count_q != FULL_COUNT);
    assign out_valid = reset && (count_q != 2'd0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
    assign out_err   = out_valid ? mem_q[rd_ptr_q][DATA_W]     : 1'b0;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {core_err, core_result};
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < EXT_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            for (int i = 0; i < EXT_DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/ext_unit.md
EXT_UNIT -- requirements
Module: ext_unit

Interface
REQ-001 SHALL take parameter DATA_W, default 32, as the datapath width (multiple of 8, at least 16).
REQ-002 SHALL take parameter IMM_W, default 16, as the immediate width (at most DATA_W).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit accepts the request this cycle.
REQ-007 SHALL have port in_mode  input  3  extension mode, per REQ-014.
REQ-008 SHALL have port in_data  input  DATA_W  raw immediate or loaded word.
REQ-009 SHALL have port in_off  input  log2(DATA_W/8)  byte offset within the word.
REQ-010 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have ports out_data (output, DATA_W, extended result) and out_err (output, 1, misalignment flag).

Function
REQ-014 SHALL implement the following modes:
- 0 ZIMM: zero-extend in_data[IMM_W-1:0].
- 1 SIMM: sign-extend in_data[IMM_W-1:0].
- 2 LUI: in_data[IMM_W-1:0] placed in the top IMM_W bits, low bits 0.
- 3 LBU / 4 LB: byte at in_off, zero- or sign-extended.
- 5 LHU / 6 LH: halfword at in_off, zero- or sign-extended.
- 7 WORD: pass-through.
REQ-015 SHALL treat byte lanes as little-endian (byte k = in_data[8k+7:8k]).
REQ-016 SHALL ignore in_off in modes 0-2 (never an error in those modes).
REQ-017 SHALL flag misalignment in these cases: modes 5/6 with in_off[0]=1; mode 7 with in_off nonzero. The stored result SHALL then be out_data=0, out_err=1.
REQ-018 SHALL compute the result combinationally at acceptance and store it in a 2-entry FIFO; results SHALL leave in acceptance order.
REQ-019 SHALL accept a request when in_valid and in_ready are both 1; out_valid SHALL rise on the next edge, giving a latency of 1 cycle.
REQ-020 SHALL pop the head entry when out_valid and out_ready are both 1.
REQ-021 SHALL drive in_ready = (count != 2); there SHALL be no combinational path from out_ready to in_ready.
REQ-022 SHALL handle simultaneous push and pop at count 1 with the count staying at 1 and order preserved.
REQ-023 SHALL allow simultaneous push and pop at count 0 (pop not possible) and at count 2 (push blocked).
REQ-024 SHALL drive out_valid = (count != 0); out_data and out_err SHALL show the head entry and be 0 when the FIFO is empty.
REQ-025 SHALL hold out_data and out_err stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on flush=1, set count to 0 at the edge; a same-cycle push and pop SHALL have no effect.
REQ-027 SHALL use 1-bit read and write pointers that wrap modulo 2.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear count, pointers and both storage entries.
REQ-029 SHALL, while reset=0, force out_valid=0, out_data=0, out_err=0 and in_ready=0.
REQ-030 SHALL raise in_ready to 1 in the first cycle after reset deasserts.
REQ-031 SHALL, on reset assertion during operation, drop all buffered entries without emitting them.

Structure
REQ-032 SHALL take the mode encodings (ZIMM..WORD) and the FIFO depth constant EXT_DEPTH=2 from shared package ext_pkg.
REQ-033 SHALL place the combinational extract/extend/misalignment logic in a sub-module ext_core; the FIFO and handshake SHALL stay in ext_unit.

Verification
REQ-034 SHALL cover mode 1, in_data=0x0000_8001 -> out_data=0xFFFF_8001 one cycle later; mode 0 with the same data -> 0x0000_8001.
REQ-035 SHALL cover mode 4, in_data=0x12F4_5678, in_off=2 -> 0xFFFF_FFF4; mode 3 -> 0x0000_00F4; mode 2, in_data=0x0000_ABCD -> 0xABCD_0000.
REQ-036 SHALL cover mode 6 with in_off=1 -> out_data=0, out_err=1; mode 7 with in_off=3 -> out_err=1.
REQ-037 SHALL cover out_ready=0 with three back-to-back requests -> in_ready low after two; releasing out_ready -> results emerge in order, none lost.
REQ-038 SHALL cover flush with count=2 plus a same-cycle push -> out_valid=0 next cycle and the pushed data never emerges.
REQ-039 SHALL cover reset asserted with count=1 -> out_valid and out_data drop immediately; after deassert, in_ready=1 and no stale output appears.
